// File: rtl/lut_cfg_pkg.sv
// Shared types and defaults for the LUT table writer: FSM state encoding,
// default geometry, and the words-per-table-image derivation.
package lut_cfg_pkg;

  localparam int unsigned IN_BITS_DEF     = 6;
  localparam int unsigned WORD_W_DEF      = 16;
  localparam int unsigned NUM_NEURONS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

  // Number of config data words that make up one truth-table image.
  function automatic int unsigned tbl_words(input int unsigned in_bits,
                                            input int unsigned word_w);
    return (32'(1) << in_bits) / word_w;
  endfunction

endpackage

// File: rtl/lut_bank.sv
// Neuron truth-table storage: one commit write port, registered lookup port
// and, when LUT_READBACK_EN is defined, a registered word readback port.
module lut_bank
  import lut_cfg_pkg::*;
#(
  parameter int unsigned IN_BITS     = IN_BITS_DEF,
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int unsigned WORD_W      = WORD_W_DEF,
  localparam int unsigned DEPTH      = 32'(1) << IN_BITS,
  localparam int unsigned TBL_WORDS  = tbl_words(IN_BITS, WORD_W),
  localparam int unsigned IDX_W      = $clog2(NUM_NEURONS),
  localparam int unsigned WSEL_W     = (TBL_WORDS > 1) ? $clog2(TBL_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [DEPTH-1:0]   wr_data_i,
  input  logic               eval_valid_i,
  input  logic [IDX_W-1:0]   eval_idx_i,
  input  logic [IN_BITS-1:0] eval_in_i,
  output logic               eval_out_o,
  output logic               eval_out_valid_o
`ifdef LUT_READBACK_EN
  ,
  input  logic               rb_valid_i,
  input  logic [IDX_W-1:0]   rb_idx_i,
  input  logic [WSEL_W-1:0]  rb_word_i,
  output logic [WORD_W-1:0]  rb_data_o,
  output logic               rb_data_valid_o
`endif
);

  logic [DEPTH-1:0] tbl_q [NUM_NEURONS];
  logic             eval_out_q;
  logic             eval_out_valid_q;
  logic             eval_hit_c;

  assign eval_hit_c = (32'(eval_idx_i) < NUM_NEURONS);

  // Reads sample tbl_q before a same-edge commit lands, so a colliding
  // lookup sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < int'(NUM_NEURONS); n++) tbl_q[n] <= '0;
      eval_out_q       <= 1'b0;
      eval_out_valid_q <= 1'b0;
    end else begin
      if (wr_en_i) tbl_q[wr_idx_i] <= wr_data_i;
      eval_out_valid_q <= eval_valid_i;
      eval_out_q       <= eval_valid_i && eval_hit_c && tbl_q[eval_idx_i][eval_in_i];
    end
  end

  assign eval_out_o       = eval_out_q;
  assign eval_out_valid_o = eval_out_valid_q;

`ifdef LUT_READBACK_EN
  logic [WORD_W-1:0] rb_data_q;
  logic              rb_data_valid_q;
  logic              rb_hit_c;

  assign rb_hit_c = (32'(rb_idx_i) < NUM_NEURONS);

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_data_q       <= '0;
      rb_data_valid_q <= 1'b0;
    end else begin
      rb_data_valid_q <= rb_valid_i;
      if (rb_valid_i && rb_hit_c) rb_data_q <= tbl_q[rb_idx_i][32'(rb_word_i)*WORD_W +: WORD_W];
      else                        rb_data_q <= '0;
    end
  end

  assign rb_data_o       = rb_data_q;
  assign rb_data_valid_o = rb_data_valid_q;
`endif

endmodule

// File: rtl/lut_table_writer.sv
// Runtime loader for a bank of neuron truth tables: parses header+data images
// from the config stream, commits them atomically, serves lookups. Optional
// word readback port is built when LUT_READBACK_EN is defined.
module lut_table_writer
  import lut_cfg_pkg::*;
#(
  parameter int unsigned IN_BITS     = IN_BITS_DEF,
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int unsigned WORD_W      = WORD_W_DEF,
  localparam int unsigned DEPTH      = 32'(1) << IN_BITS,
  localparam int unsigned TBL_WORDS  = tbl_words(IN_BITS, WORD_W),
  localparam int unsigned IDX_W      = $clog2(NUM_NEURONS),
  localparam int unsigned WSEL_W     = (TBL_WORDS > 1) ? $clog2(TBL_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WORD_W-1:0]  cfg_data,
  input  logic               cfg_last,
  output logic               cfg_busy,
  output logic               cfg_err,
  output logic               commit_pulse,
  input  logic               eval_valid,
  input  logic [IDX_W-1:0]   eval_idx,
  input  logic [IN_BITS-1:0] eval_in,
  output logic               eval_out,
  output logic               eval_out_valid
`ifdef LUT_READBACK_EN
  ,
  input  logic               rb_valid,
  input  logic [IDX_W-1:0]   rb_idx,
  input  logic [WSEL_W-1:0]  rb_word,
  output logic [WORD_W-1:0]  rb_data,
  output logic               rb_data_valid
`endif
);

  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(TBL_WORDS - 1);

  cfg_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WSEL_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  shadow_q, shadow_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              commit_q, commit_d;
  logic              accept_c;
  logic              hdr_oor_c;

  assign accept_c  = cfg_valid && ready_q;
  // Range check uses the whole header word so stray upper bits cannot alias
  // onto a valid neuron.
  assign hdr_oor_c = (32'(cfg_data) >= NUM_NEURONS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          err_d = 1'b0;
          if (cfg_last) begin
            err_d = 1'b1;
          end else if (hdr_oor_c) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            idx_d   = cfg_data[IDX_W-1:0];
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept_c) begin
          shadow_d[32'(cnt_q)*WORD_W +: WORD_W] = cfg_data;
          cnt_d = WSEL_W'(cnt_q + 1'b1);
          if (cnt_q == LAST_WORD) begin
            if (cfg_last) begin
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (cfg_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (accept_c && cfg_last) state_d = IDLE;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status outputs are registered images of the next state.
    ready_d  = (state_d != COMMIT);
    busy_d   = (state_d != IDLE);
    commit_d = (state_d == COMMIT);
  end

  assign cfg_ready    = ready_q;
  assign cfg_busy     = busy_q;
  assign cfg_err      = err_q;
  assign commit_pulse = commit_q;

  lut_bank #(
    .IN_BITS     (IN_BITS),
    .NUM_NEURONS (NUM_NEURONS),
    .WORD_W      (WORD_W)
  ) u_bank (
    .clk              (clk),
    .rst              (rst),
    .wr_en_i          (state_q == COMMIT),
    .wr_idx_i         (idx_q),
    .wr_data_i        (shadow_q),
    .eval_valid_i     (eval_valid),
    .eval_idx_i       (eval_idx),
    .eval_in_i        (eval_in),
    .eval_out_o       (eval_out),
    .eval_out_valid_o (eval_out_valid)
`ifdef LUT_READBACK_EN
    ,
    .rb_valid_i       (rb_valid),
    .rb_idx_i         (rb_idx),
    .rb_word_i        (rb_word),
    .rb_data_o        (rb_data),
    .rb_data_valid_o  (rb_data_valid)
`endif
  );

endmodule
